// File: rtl/display_pkg.sv
// Shared constants for the two-digit display scanner: segment patterns,
// digit-select encodings and the scan-state type.
package display_pkg;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   // Segment order is {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] SEG_0    = 7'h3F;
   localparam logic [6:0] SEG_1    = 7'h06;
   localparam logic [6:0] SEG_2    = 7'h5B;
   localparam logic [6:0] SEG_3    = 7'h4F;
   localparam logic [6:0] SEG_4    = 7'h66;
   localparam logic [6:0] SEG_5    = 7'h6D;
   localparam logic [6:0] SEG_6    = 7'h7D;
   localparam logic [6:0] SEG_7    = 7'h07;
   localparam logic [6:0] SEG_8    = 7'h7F;
   localparam logic [6:0] SEG_9    = 7'h6F;
   localparam logic [6:0] SEG_DASH = 7'h40;
   localparam logic [6:0] SEG_OFF  = 7'h00;

   localparam logic DIGIT_UNITS = 1'b0;
   localparam logic DIGIT_TENS  = 1'b1;

endpackage

// File: rtl/display_scanner_bcd_to_7seg.sv
// Pure combinational BCD to 7-segment decoder; any non-BCD nibble
// renders as a dash so corrupted counts are visibly flagged.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/display_scanner.sv
// Two-digit multiplexed 7-segment scanner: shadows the BCD result on load and
// alternates units/tens on a shared segment bus with an anti-ghosting blank gap.
module display_scanner
   import display_pkg::*;
#(
   parameter logic [7:0]  REFRESH_DIV   = 8'd100,
   parameter int unsigned BLANK_CYCLES  = 2,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic [3:0] ten_count,
   input  logic [3:0] unit_count,
   output logic [6:0] segments,
   output logic       digit
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 8'd1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

   logic [3:0]    shadow_tens;
   logic [3:0]    shadow_units;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   scan_state_e   state;
   scan_state_e   state_next;
   logic          digit_next;
   logic [3:0]    sel_nibble;
   logic [6:0]    dec_seg;
   logic          leading_blank;
   logic [6:0]    segments_next;

   // Slot sequencing: every slot opens in BLANK, then switches to SHOW once the
   // gap has elapsed; the last count of a slot hands over to the other digit.
   always_comb begin
      cnt_next   = cnt + 1'b1;
      state_next = state;
      digit_next = digit;
      if (cnt == CNT_LAST) begin
         cnt_next   = '0;
         digit_next = ~digit;
         state_next = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
      end else if (state == ST_BLANK) begin
         if ((BLANK_CYCLES == 0) || (cnt == BLANK_LAST)) begin
            state_next = ST_SHOW;
         end
      end
   end

   // Decode looks at the digit and state being entered, so segments and digit
   // update on the same edge and the bus is dark whenever the digit toggles.
   always_comb begin
      sel_nibble    = (digit_next == DIGIT_TENS) ? shadow_tens : shadow_units;
      leading_blank = BLANK_LEADING && (digit_next == DIGIT_TENS) && (shadow_tens == 4'd0);
      segments_next = SEG_OFF;
      if ((state_next == ST_SHOW) && !leading_blank) begin
         segments_next = dec_seg;
      end
   end

   bcd_to_7seg u_decoder (
      .bcd (sel_nibble),
      .seg (dec_seg)
   );

   // Reset dominates load so a frame in progress is discarded completely.
   always_ff @(posedge clk) begin
      if (!reset) begin
         shadow_tens  <= 4'd0;
         shadow_units <= 4'd0;
         cnt          <= '0;
         state        <= ST_BLANK;
         digit        <= DIGIT_UNITS;
         segments     <= SEG_OFF;
      end else begin
         if (load) begin
            shadow_tens  <= ten_count;
            shadow_units <= unit_count;
         end
         cnt      <= cnt_next;
         state    <= state_next;
         digit    <= digit_next;
         segments <= segments_next;
      end
   end

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner: vector table, hand-written timing
// sequences and a randomized run, all compared against a cycle-level reference model.
module tb_display_scanner;

   localparam logic [7:0] RDIV   = 8'd8;
   localparam int         RDIV_I = 8;
   localparam int         BLANKS = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] ten_count = 4'd0;
   logic [3:0] unit_count = 4'd0;
   logic [6:0] seg_a;
   logic       dig_a;
   logic [6:0] seg_b;
   logic       dig_b;

   display_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANKS), .BLANK_LEADING(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .ten_count  (ten_count),
      .unit_count (unit_count),
      .segments   (seg_a),
      .digit      (dig_a)
   );

   display_scanner #(.REFRESH_DIV(RDIV), .BLANK_CYCLES(BLANKS), .BLANK_LEADING(1'b0)) dut_nl (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .ten_count  (ten_count),
      .unit_count (unit_count),
      .segments   (seg_b),
      .digit      (dig_b)
   );

   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state: cycles since the last reset edge and the shadow
   // contents during the current and previous cycle.
   bit         model_valid = 1'b0;
   int         phase = 0;
   int         last_p = 0;
   logic [3:0] sh_t = 4'd0, sh_u = 4'd0, prev_t = 4'd0, prev_u = 4'd0;

   typedef struct {
      logic [3:0] tens;
      logic [3:0] units;
      logic [6:0] exp_units;
      logic [6:0] exp_tens_bl;
      logic [6:0] exp_tens_nl;
   } vec_t;

   vec_t vecs[5];

   function automatic logic [6:0] ref_seg(input logic [3:0] v, input bit is_tens, input bit bl);
      logic [6:0] r;
      case (v)
         4'd0:    r = 7'h3F;
         4'd1:    r = 7'h06;
         4'd2:    r = 7'h5B;
         4'd3:    r = 7'h4F;
         4'd4:    r = 7'h66;
         4'd5:    r = 7'h6D;
         4'd6:    r = 7'h7D;
         4'd7:    r = 7'h07;
         4'd8:    r = 7'h7F;
         4'd9:    r = 7'h6F;
         default: r = 7'h40;
      endcase
      if (is_tens && bl && (v == 4'd0)) r = 7'h00;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s (phase %0d): got 0x%02h, expected 0x%02h", name, last_p, actual, expected);
      end
   endtask

   // Observe the current cycle against the model, then drive this cycle's inputs.
   task automatic applyStimulus(input logic rst_n, input logic ld, input logic [3:0] t, input logic [3:0] u);
      int         pos;
      bit         tens_slot;
      logic [3:0] v;
      logic [6:0] exp_a;
      logic [6:0] exp_b;
      @(negedge clk);
      last_p = phase;
      if (model_valid) begin
         pos       = phase % RDIV_I;
         tens_slot = ((phase / RDIV_I) % 2) == 1;
         v         = tens_slot ? prev_t : prev_u;
         exp_a     = 7'h00;
         exp_b     = 7'h00;
         if (pos >= BLANKS) begin
            exp_a = ref_seg(v, tens_slot, 1'b1);
            exp_b = ref_seg(v, tens_slot, 1'b0);
         end
         checkOutput("model_segments_bl1", seg_a, exp_a);
         checkOutput("model_segments_bl0", seg_b, exp_b);
         checkOutput("model_digit_bl1", {6'd0, dig_a}, {6'd0, tens_slot});
         checkOutput("model_digit_bl0", {6'd0, dig_b}, {6'd0, tens_slot});
      end
      reset      = rst_n;
      load       = ld;
      ten_count  = t;
      unit_count = u;
      prev_t = sh_t;
      prev_u = sh_u;
      if (!rst_n) begin
         model_valid = 1'b1;
         phase = 0;
         sh_t  = 4'd0;
         sh_u  = 4'd0;
      end else begin
         phase++;
         if (ld) begin
            sh_t = t;
            sh_u = u;
         end
      end
   endtask

   // Fixed expectations for the first frame after reset with zero shadow.
   task automatic check_idle_frame();
      logic [6:0] exp_s;
      exp_s = (last_p >= 2 && last_p < 8) ? 7'h3F : 7'h00;
      checkOutput("idle_frame_segments", seg_a, exp_s);
      checkOutput("idle_frame_digit", {6'd0, dig_a}, (last_p >= 8) ? 7'd1 : 7'd0);
   endtask

   initial begin
      vecs[0] = '{4'd4, 4'd2, 7'h5B, 7'h66, 7'h66};
      vecs[1] = '{4'd0, 4'd7, 7'h07, 7'h00, 7'h3F};
      vecs[2] = '{4'hC, 4'hA, 7'h40, 7'h40, 7'h40};
      vecs[3] = '{4'd9, 4'd8, 7'h7F, 7'h6F, 7'h6F};
      vecs[4] = '{4'd1, 4'd0, 7'h3F, 7'h06, 7'h06};

      // Reset then release with no load.
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
         check_idle_frame();
      end

      // Table of loaded values, checked mid-slot on both blanking variants.
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
         applyStimulus(1'b1, 1'b1, vecs[k].tens, vecs[k].units);
         for (int c = 1; c < 16; c++) begin
            applyStimulus(1'b1, 1'b0, 4'hF, 4'hF);
            if (last_p == 4) begin
               checkOutput("vec_units_bl1", seg_a, vecs[k].exp_units);
               checkOutput("vec_units_bl0", seg_b, vecs[k].exp_units);
            end
            if (last_p == 12) begin
               checkOutput("vec_tens_bl1", seg_a, vecs[k].exp_tens_bl);
               checkOutput("vec_tens_bl0", seg_b, vecs[k].exp_tens_nl);
            end
         end
      end

      // Load mid-SHOW changes 42 to 43 two edges later without disturbing timing.
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd4, 4'd2);
      for (int c = 1; c < 4; c++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd4, 4'd3);
      checkOutput("midshow_before", seg_a, 7'h5B);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("midshow_hold", seg_a, 7'h5B);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("midshow_switch", seg_a, 7'h4F);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("midshow_digit_p7", {6'd0, dig_a}, 7'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("toggle_digit_p8", {6'd0, dig_a}, 7'd1);
      checkOutput("toggle_blank_p8", seg_a, 7'h00);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("midshow_tens", seg_a, 7'h66);

      // One-cycle reset mid tens slot restarts the scan from scratch.
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
         check_idle_frame();
      end

      // Load coinciding with the digit toggle lands in the new slot.
      applyStimulus(1'b0, 1'b0, 4'd0, 4'd0);
      for (int c = 0; c < 7; c++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      applyStimulus(1'b1, 1'b1, 4'd5, 4'd6);
      for (int c = 8; c <= 10; c++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("toggle_load_tens", seg_a, 7'h6D);
      for (int c = 11; c <= 18; c++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);
      checkOutput("toggle_load_units", seg_a, 7'h7D);

      // Randomized traffic with occasional resets, checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(($urandom_range(0, 299) != 0),
                       ($urandom_range(0, 7) == 0),
                       4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)));
      end
      applyStimulus(1'b1, 1'b0, 4'd0, 4'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
